// File: rtl/class_arbiter.sv
// Two-class weighted round-robin arbiter between FWFT FIFOs and two paused destinations.
// Registered output word with one-cycle latency and an urgent almost-full override.
module class_arbiter #(
    parameter int WEIGHT0 = 3,
    parameter int WEIGHT1 = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] fifo0_data,
    input  logic       fifo0_empty,
    input  logic       fifo0_almost_full,
    input  logic [9:0] fifo1_data,
    input  logic       fifo1_empty,
    input  logic       fifo1_almost_full,
    input  logic       dest0_pause,
    input  logic       dest1_pause,
    output logic       read0,
    output logic       read1,
    output logic [9:0] data_out,
    output logic       valid_out,
    output logic       dest_sel,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } state_t;

    localparam logic [3:0] LOAD0 = 4'(WEIGHT0 - 1);
    localparam logic [3:0] LOAD1 = 4'(WEIGHT1 - 1);

    state_t     state;
    logic [3:0] credit;
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;

    function automatic logic eligible(input logic empty, input logic dsel,
                                      input logic p0, input logic p1);
        return !empty && !(dsel ? p1 : p0);
    endfunction

    function automatic logic [3:0] dec_sat(input logic [3:0] c);
        return (c != 4'd0) ? c - 4'd1 : 4'd0;
    endfunction

    assign elig0 = eligible(fifo0_empty, fifo0_data[8], dest0_pause, dest1_pause);
    assign elig1 = eligible(fifo1_empty, fifo1_data[8], dest0_pause, dest1_pause);

    // Grant decision: combinational from state, credit and current FIFO/pause inputs.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                if (fifo0_almost_full != fifo1_almost_full) begin
                    grant0 = fifo0_almost_full;
                    grant1 = fifo1_almost_full;
                end else begin
                    case (state)
                        SERVE0: begin
                            grant0 = (credit != 4'd0);
                            grant1 = (credit == 4'd0);
                        end
                        SERVE1: begin
                            grant1 = (credit != 4'd0);
                            grant0 = (credit == 4'd0);
                        end
                        default: grant0 = 1'b1;
                    endcase
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign read0     = grant0;
    assign read1     = grant1;
    assign arb_state = state;

    // Output stage: granted word registered one cycle after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            credit    <= 4'd0;
            valid_out <= 1'b0;
            data_out  <= 10'd0;
            dest_sel  <= 1'b0;
        end else begin
            valid_out <= grant0 | grant1;
            if (grant0) begin
                data_out <= fifo0_data;
                dest_sel <= fifo0_data[8];
                if (state == SERVE0) begin
                    credit <= dec_sat(credit);
                end else begin
                    credit <= LOAD0;
                    state  <= SERVE0;
                end
            end else if (grant1) begin
                data_out <= fifo1_data;
                dest_sel <= fifo1_data[8];
                if (state == SERVE1) begin
                    credit <= dec_sat(credit);
                end else begin
                    credit <= LOAD1;
                    state  <= SERVE1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_class_arbiter.sv
// Bench for class_arbiter: directed scenarios plus randomized traffic checked
// against a class-indexed behavioural model of the weighted arbitration rules.
module tb_class_arbiter;

    localparam int W0 = 3;
    localparam int W1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] fifo0_data, fifo1_data;
    logic       fifo0_empty, fifo1_empty;
    logic       fifo0_almost_full, fifo1_almost_full;
    logic       dest0_pause, dest1_pause;
    logic       read0, read1;
    logic [9:0] data_out;
    logic       valid_out;
    logic       dest_sel;
    logic [1:0] arb_state;

    int total = 0;
    int bad   = 0;

    // Model: m_serving = -1 when idle, else the class being served.
    int         m_serving;
    int         m_credit;
    logic       m_valid;
    logic [9:0] m_data;
    logic       m_dest;

    class_arbiter #(.WEIGHT0(W0), .WEIGHT1(W1)) dut (
        .clk(clk), .reset(reset),
        .fifo0_data(fifo0_data), .fifo0_empty(fifo0_empty), .fifo0_almost_full(fifo0_almost_full),
        .fifo1_data(fifo1_data), .fifo1_empty(fifo1_empty), .fifo1_almost_full(fifo1_almost_full),
        .dest0_pause(dest0_pause), .dest1_pause(dest1_pause),
        .read0(read0), .read1(read1),
        .data_out(data_out), .valid_out(valid_out), .dest_sel(dest_sel), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        logic [9:0] head [2];
        logic       emp  [2];
        logic       af   [2];
        logic       pause[2];
        bit         ok   [2];
        head[0] = fifo0_data;  head[1] = fifo1_data;
        emp[0]  = fifo0_empty; emp[1]  = fifo1_empty;
        af[0]   = fifo0_almost_full; af[1] = fifo1_almost_full;
        pause[0] = dest0_pause; pause[1] = dest1_pause;
        for (int c = 0; c < 2; c++)
            ok[c] = (emp[c] === 1'b0) && (pause[int'(head[c][8])] === 1'b0);
        if (reset) return -1;
        if (!ok[0] && !ok[1]) return -1;
        if (ok[0] != ok[1]) return ok[0] ? 0 : 1;
        if (af[0] != af[1]) return af[0] ? 0 : 1;
        if (m_serving < 0) return 0;
        return (m_credit > 0) ? m_serving : 1 - m_serving;
    endfunction

    function automatic int expected_state_code();
        return (m_serving < 0) ? 0 : m_serving + 1;
    endfunction

    task automatic tick();
        int g;
        int weight[2];
        logic [9:0] word;
        weight[0] = W0; weight[1] = W1;
        g = model_grant();
        word = (g == 1) ? fifo1_data : fifo0_data;
        @(posedge clk);
        if (reset) begin
            m_serving = -1; m_credit = 0; m_valid = 0; m_data = '0; m_dest = 0;
        end else if (g < 0) begin
            m_serving = -1; m_valid = 0;
        end else begin
            if (m_serving == g) m_credit = (m_credit > 0) ? m_credit - 1 : 0;
            else begin m_credit = weight[g] - 1; m_serving = g; end
            m_valid = 1; m_data = word; m_dest = word[8];
        end
        #1;
    endtask

    task automatic set_idle_inputs();
        fifo0_data = '0; fifo1_data = '0;
        fifo0_empty = 1; fifo1_empty = 1;
        fifo0_almost_full = 0; fifo1_almost_full = 0;
        dest0_pause = 0; dest1_pause = 0;
    endtask

    task automatic test_reset();
        set_idle_inputs();
        fifo0_empty = 0; fifo1_empty = 0;
        fifo0_data = 10'h055; fifo1_data = 10'h066;
        reset = 1;
        #2;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (read0 !== 1'b0 || read1 !== 1'b0) begin
                bad++; $display("FAIL reset_reads: got %b%b want 00", read0, read1);
            end
            tick();
            #1;
        end
        total++;
        if (valid_out !== 1'b0 || data_out !== 10'h000 || dest_sel !== 1'b0 || arb_state !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h s=%b st=%b want 0 000 0 00",
                     valid_out, data_out, dest_sel, arb_state);
        end
    endtask

    task automatic test_weighted_order();
        int order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        logic [9:0] w;
        set_idle_inputs();
        fifo0_empty = 0; fifo1_empty = 0;
        fifo0_data = 10'h011; fifo1_data = 10'h022;
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            total++;
            if (read0 !== (order[i] == 0) || read1 !== (order[i] == 1)) begin
                bad++; $display("FAIL order[%0d]: got r0=%b r1=%b want class %0d", i, read0, read1, order[i]);
            end
            tick();
            w = (order[i] == 0) ? 10'h011 : 10'h022;
            total++;
            if (valid_out !== 1'b1 || data_out !== w) begin
                bad++; $display("FAIL order_out[%0d]: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, w);
            end
        end
    endtask

    task automatic test_only_class1();
        logic [9:0] heads[2] = '{10'h0DD, 10'h0EE};
        set_idle_inputs();
        fifo1_empty = 0;
        for (int i = 0; i < 2; i++) begin
            fifo1_data = heads[i];
            #2;
            total++;
            if (read0 !== 1'b0 || read1 !== 1'b1) begin
                bad++; $display("FAIL only1_read[%0d]: got %b%b want r0=0 r1=1", i, read0, read1);
            end
            tick();
            total++;
            if (valid_out !== 1'b1 || data_out !== heads[i] || arb_state !== 2'b10) begin
                bad++; $display("FAIL only1_out[%0d]: got v=%b d=%h st=%b want 1 %h 10",
                                i, valid_out, data_out, arb_state, heads[i]);
            end
        end
    endtask

    task automatic test_pause_block();
        set_idle_inputs();
        fifo0_empty = 0; fifo0_data = 10'h1FF;
        fifo1_empty = 0; fifo1_data = 10'h0CC;
        dest1_pause = 1;
        #2;
        total++;
        if (read0 !== 1'b0 || read1 !== 1'b1) begin
            bad++; $display("FAIL pause_read: got r0=%b r1=%b want r0=0 r1=1", read0, read1);
        end
        tick();
        total++;
        if (valid_out !== 1'b1 || data_out !== 10'h0CC || dest_sel !== 1'b0) begin
            bad++; $display("FAIL pause_out: got v=%b d=%h s=%b want 1 0cc 0", valid_out, data_out, dest_sel);
        end
    endtask

    task automatic test_override();
        set_idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        fifo0_empty = 0; fifo0_data = 10'h101;
        fifo1_empty = 0; fifo1_data = 10'h002;
        tick();
        fifo1_almost_full = 1;
        #2;
        total++;
        if (read0 !== 1'b0 || read1 !== 1'b1) begin
            bad++; $display("FAIL override_read: got r0=%b r1=%b want r0=0 r1=1", read0, read1);
        end
        tick();
        total++;
        if (arb_state !== 2'b10 || data_out !== 10'h002) begin
            bad++; $display("FAIL override_state: got st=%b d=%h want 10 002", arb_state, data_out);
        end
        // Credit loaded as zero: with both eligible the next grant switches to class 0.
        fifo1_almost_full = 0;
        #2;
        total++;
        if (read0 !== 1'b1 || read1 !== 1'b0) begin
            bad++; $display("FAIL override_credit: got r0=%b r1=%b want r0=1 r1=0", read0, read1);
        end
        tick();
    endtask

    task automatic test_reset_midburst();
        set_idle_inputs();
        fifo0_empty = 0; fifo0_data = 10'h033;
        fifo1_empty = 0; fifo1_data = 10'h044;
        tick();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            total++;
            if (read0 !== 1'b0 || read1 !== 1'b0) begin
                bad++; $display("FAIL midreset_read[%0d]: got %b%b want 00", i, read0, read1);
            end
            tick();
            total++;
            if (valid_out !== 1'b0 || arb_state !== 2'b00) begin
                bad++; $display("FAIL midreset_out[%0d]: got v=%b st=%b want 0 00", i, valid_out, arb_state);
            end
        end
        reset = 0;
        #2;
        total++;
        if (read0 !== 1'b1 || read1 !== 1'b0) begin
            bad++; $display("FAIL midreset_restart: got r0=%b r1=%b want r0=1 r1=0", read0, read1);
        end
        tick();
    endtask

    task automatic test_empty_hold();
        logic [9:0] last;
        last = data_out;
        set_idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (read0 !== 1'b0 || read1 !== 1'b0) begin
                bad++; $display("FAIL empty_read[%0d]: got %b%b want 00", i, read0, read1);
            end
            tick();
            total++;
            if (valid_out !== 1'b0 || data_out !== last || arb_state !== 2'b00) begin
                bad++; $display("FAIL empty_out[%0d]: got v=%b d=%h st=%b want 0 %h 00",
                                i, valid_out, data_out, arb_state, last);
            end
        end
    endtask

    task automatic test_random();
        int g;
        int pops = 0;
        int valids = 0;
        reset = 1;
        tick();
        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 49) == 0);
            fifo0_data        = 10'($urandom);
            fifo1_data        = 10'($urandom);
            fifo0_empty       = ($urandom_range(0, 3) == 0);
            fifo1_empty       = ($urandom_range(0, 3) == 0);
            fifo0_almost_full = ($urandom_range(0, 5) == 0);
            fifo1_almost_full = ($urandom_range(0, 5) == 0);
            dest0_pause       = ($urandom_range(0, 4) == 0);
            dest1_pause       = ($urandom_range(0, 4) == 0);
            #2;
            g = model_grant();
            total++;
            if (read0 !== (g == 0) || read1 !== (g == 1)) begin
                bad++; $display("FAIL rand_read[%0d]: got r0=%b r1=%b want grant %0d", i, read0, read1, g);
            end
            if (g >= 0) pops++;
            tick();
            if (valid_out === 1'b1) valids++;
            total++;
            if (valid_out !== m_valid || data_out !== m_data || dest_sel !== m_dest ||
                arb_state !== 2'(expected_state_code())) begin
                bad++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%b st=%b want v=%b d=%h s=%b st=%0d",
                         i, valid_out, data_out, dest_sel, arb_state,
                         m_valid, m_data, m_dest, expected_state_code());
            end
        end
        total++;
        if (pops != valids) begin
            bad++; $display("FAIL rand_lossless: got valids=%0d want pops=%0d", valids, pops);
        end
    endtask

    initial begin
        m_serving = -1; m_credit = 0; m_valid = 0; m_data = '0; m_dest = 0;
        reset = 1;
        set_idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_weighted_order();
        test_only_class1();
        test_pause_block();
        test_override();
        test_reset_midburst();
        test_empty_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
